dot_result_buffer: RTL and testbench

DOT_RESULT_BUFFER -- requirements
Module: dot_result_buffer

---
 rtl/dot_pkg.sv | 9 +
 rtl/dot_fifo_core.sv | 64 ++++++
 rtl/dot_result_buffer.sv | 58 +++++
 tb/tb_dot_result_buffer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Constants shared by the dot-product datapath and its result buffer.
// DOT_W is the dot-product result width that both stages agree on.
package dot_pkg;

    localparam int DOT_W         = 18;
    localparam int BYTE_W        = 8;
    localparam int DOT_BUF_DEPTH = 4;

endpackage

// File: rtl/dot_fifo_core.sv
// Storage, pointers and fill count for the dot-product result buffer.
// Also decides whether an incoming write is accepted or dropped.
module dot_fifo_core #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 18,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_req,
    input  logic              i_rd_req,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_push,
    output logic              o_drop
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    // A full buffer still takes a write when the head leaves in the same cycle.
    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = o_valid && i_rd_req;
    assign w_push = i_wr_req && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the head is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_valid   = (r_count != '0);
    assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count   = r_count;
    assign o_push    = w_push;
    assign o_drop    = i_wr_req && w_full && !w_pop;

endmodule

// File: rtl/dot_result_buffer.sv
// Result buffer behind the dot-product stage: FIFO plus a sticky drop flag
// and a running maximum of every accepted result.
module dot_result_buffer
    import dot_pkg::*;
#(
    parameter int DEPTH  = DOT_BUF_DEPTH,
    parameter int DATA_W = DOT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_run,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [DATA_W-1:0]        max_data
);

    logic w_push;
    logic w_drop;
    logic r_overflow;
    logic [DATA_W-1:0] r_max;

    dot_fifo_core #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .i_wr_data (in_data),
        .i_wr_req  (in_run),
        .i_rd_req  (out_ready),
        .o_rd_data (out_data),
        .o_valid   (out_valid),
        .o_count   (count),
        .o_push    (w_push),
        .o_drop    (w_drop)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_max      <= '0;
        end else begin
            if (w_drop)       r_overflow <= 1'b1;
            else if (clr_ovf) r_overflow <= 1'b0;
            if (w_push && (in_data > r_max)) r_max <= in_data;
        end
    end

    assign overflow = r_overflow;
    assign max_data = r_max;

endmodule

// File: tb/tb_dot_result_buffer.sv
// Directed bench for dot_result_buffer with hand-computed expectations.
module tb_dot_result_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 18;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_run;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        count;
    logic              overflow;
    logic              clr_ovf;
    logic [DATA_W-1:0] max_data;

    int checks   = 0;
    int failures = 0;

    dot_result_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_run    (in_run),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .max_data  (max_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        in_run  = 1'b1;
        in_data = v;
        step();
        in_run  = 1'b0;
        in_data = '0;
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_run = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        step();
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_max", 32'(max_data), 0);
        reset = 1'b0;

        // Three results held back by the consumer, then drained in order.
        push(0); push(32); push(50);
        chk("hold_count", 32'(count), 3);
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 0);
        chk("hold_max", 32'(max_data), 50);
        step();
        chk("hold_stable", 32'(out_data), 0);
        out_ready = 1'b1;
        chk("drain0", 32'(out_data), 0);
        step();
        chk("drain1", 32'(out_data), 32);
        step();
        chk("drain2", 32'(out_data), 50);
        step();
        chk("drain_empty_valid", 32'(out_valid), 0);
        chk("drain_empty_data", 32'(out_data), 0);
        step();
        chk("empty_ready_count", 32'(count), 0);
        out_ready = 1'b0;

        // No bypass: push into empty is visible one cycle later.
        in_run = 1'b1; in_data = 32;
        chk("lat_push_cycle_valid", 32'(out_valid), 0);
        step();
        in_run = 1'b0; in_data = '0;
        chk("lat_next_valid", 32'(out_valid), 1);
        chk("lat_next_data", 32'(out_data), 32);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("lat_popped_count", 32'(count), 0);

        // Asynchronous reset with three entries stored.
        push(5); push(6); push(7);
        chk("pre_rst_count", 32'(count), 3);
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_max", 32'(max_data), 0);
        step();
        reset = 1'b0;

        // Fill, then overflow, then clear behaviour.
        push(1); push(2); push(3); push(4);
        chk("full_count", 32'(count), 4);
        push(99);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_max", 32'(max_data), 4);
        chk("ovf_head", 32'(out_data), 1);
        in_run = 1'b1; in_data = 88; clr_ovf = 1'b1;
        step();
        in_run = 1'b0; in_data = '0;
        chk("ovf_set_wins", 32'(overflow), 1);
        chk("ovf_set_wins_max", 32'(max_data), 4);
        step();
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Push and pop together while full.
        in_run = 1'b1; in_data = 7; out_ready = 1'b1;
        step();
        in_run = 1'b0; in_data = '0; out_ready = 1'b0;
        chk("full_pp_count", 32'(count), 4);
        chk("full_pp_head", 32'(out_data), 2);
        chk("full_pp_max", 32'(max_data), 7);
        chk("full_pp_ovf", 32'(overflow), 0);
        out_ready = 1'b1;
        chk("full_drain0", 32'(out_data), 2);
        step();
        chk("full_drain1", 32'(out_data), 3);
        step();
        chk("full_drain2", 32'(out_data), 4);
        step();
        chk("full_drain3", 32'(out_data), 7);
        step();
        chk("full_drain_valid", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Ten values through with simultaneous push/pop; pointers wrap twice.
        push(1);
        for (int i = 2; i <= 10; i++) begin
            in_run = 1'b1; in_data = DATA_W'(i); out_ready = 1'b1;
            chk("wrap_order", 32'(out_data), 32'(i - 1));
            step();
            chk("wrap_count", 32'(count), 1);
        end
        in_run = 1'b0; in_data = '0;
        chk("wrap_last", 32'(out_data), 10);
        step();
        out_ready = 1'b0;
        chk("wrap_end_valid", 32'(out_valid), 0);
        chk("wrap_end_max", 32'(max_data), 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
